// File: rtl/md_hilo_ctrl.sv
// HI/LO multiply/divide controller: single-cycle 32x32 multiply, 32-step restoring divide,
// and MTHI/MTLO pass-through, each finishing with a one-cycle write-back to the HI/LO file.
module md_hilo_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_src1,
    input  logic [31:0] req_src2,
    input  logic        flush,
    output logic        busy,
    output logic        we_hi,
    output logic [31:0] wdata_hi,
    output logic        we_lo,
    output logic [31:0] wdata_lo
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;
    localparam logic [1:0] S_WB   = 2'd3;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    logic [1:0]  state;
    logic [5:0]  cnt;
    logic [2:0]  op_q;
    logic [31:0] src1_q;
    logic [31:0] src2_q;
    logic [31:0] rem_q;
    logic [31:0] quo_q;
    logic [31:0] dvs_q;
    logic [31:0] res_hi;
    logic [31:0] res_lo;

    logic        accept;
    logic [63:0] mul_a;
    logic [63:0] mul_b;
    logic [63:0] product;
    logic        neg1;
    logic        neg2;
    logic [32:0] shifted;
    logic        fits;
    logic [31:0] rem_nx;
    logic [31:0] quo_nx;
    logic        wb_live;

    assign req_ready = (state == S_IDLE) && !flush && !reset;
    assign accept    = req_valid && req_ready;
    assign busy      = (state != S_IDLE);

    // Sign-extending to 64 bits lets one multiplier serve both MULT and MULTU.
    assign mul_a   = {{32{(op_q == OP_MULT) & src1_q[31]}}, src1_q};
    assign mul_b   = {{32{(op_q == OP_MULT) & src2_q[31]}}, src2_q};
    assign product = mul_a * mul_b;

    assign neg1 = (op_q == OP_DIV) & src1_q[31];
    assign neg2 = (op_q == OP_DIV) & src2_q[31];

    // One restoring step: shift the next dividend bit in, subtract when it fits.
    // A successful subtraction leaves less than the divisor, so 32-bit wraparound is exact.
    assign shifted = {rem_q, quo_q[31]};
    assign fits    = shifted >= {1'b0, dvs_q};
    assign rem_nx  = fits ? (shifted[31:0] - dvs_q) : shifted[31:0];
    assign quo_nx  = {quo_q[30:0], fits};

    // Writes are suppressed in the same cycle by flush or reset, not only on the next edge.
    assign wb_live  = (state == S_WB) && !flush && !reset;
    assign we_hi    = wb_live && (op_q != OP_MTLO);
    assign we_lo    = wb_live && (op_q != OP_MTHI);
    assign wdata_hi = we_hi ? res_hi : 32'd0;
    assign wdata_lo = we_lo ? res_lo : 32'd0;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            cnt   <= 6'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        case (req_op)
                            OP_MULT, OP_MULTU: state <= S_MUL;
                            OP_DIV, OP_DIVU: begin
                                state <= S_DIV;
                                cnt   <= 6'd0;
                            end
                            OP_MTHI, OP_MTLO:  state <= S_WB;
                            default:           state <= S_IDLE;
                        endcase
                    end
                end
                S_MUL: state <= flush ? S_IDLE : S_WB;
                S_DIV: begin
                    if (flush) begin
                        state <= S_IDLE;
                    end else if (cnt == 6'd0) begin
                        if (src2_q == 32'd0) state <= S_IDLE;
                        else                 cnt   <= 6'd1;
                    end else if (cnt == 6'd32) begin
                        state <= S_WB;
                    end else begin
                        cnt <= cnt + 6'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // NOTE: datapath registers carry no reset; the FSM never lets a write expose them before they are loaded.
    always_ff @(posedge clk) begin
        if (state == S_IDLE && accept) begin
            op_q   <= req_op;
            src1_q <= req_src1;
            src2_q <= req_src2;
            res_hi <= req_src1;
            res_lo <= req_src1;
        end else if (state == S_MUL) begin
            res_hi <= product[63:32];
            res_lo <= product[31:0];
        end else if (state == S_DIV) begin
            if (cnt == 6'd0) begin
                rem_q <= 32'd0;
                quo_q <= neg1 ? -src1_q : src1_q;
                dvs_q <= neg2 ? -src2_q : src2_q;
            end else begin
                rem_q <= rem_nx;
                quo_q <= quo_nx;
                if (cnt == 6'd32) begin
                    res_lo <= (neg1 ^ neg2) ? -quo_nx : quo_nx;
                    res_hi <= neg1 ? -rem_nx : rem_nx;
                end
            end
        end
    end

endmodule
